data_mem: RTL and testbench
===========================

Name: data_mem

Overview:
- Single-port, word-addressed data memory for the RV32 single-cycle core; sits on the load/store path after the ALU address computation.
- Writes are synchronous full 32-bit words. Reads are asynchronous (combinational).
- Synchronous reset clears the entire array to zero, so software sees a zero-initialised data space.

Parameters:
- XLEN, 32, data and address width in bits.
- DEPTH, 256, number of 32-bit words (1 KiB); must be a power of two.
- AW, $clog2(DEPTH), word-index width (derived; not overridden).

Ports:
- clk    input   1       single clock; all state updates on rising edge
- rst    input   1       synchronous, active-high reset; clears every word
- we     input   1       write enable; a write occurs on the rising edge when high
- addr   input   XLEN    byte address from the ALU
- wdata  input   XLEN    store data
- rdata  output  XLEN    load data, combinational from addr

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Storage: array mem[0:DEPTH-1] of XLEN-bit words.
- Word index is addr[AW+1:2].
  - addr[1:0] is ignored; misaligned addresses alias to the containing word.
  - No byte or halfword lanes.
- In range means addr[XLEN-1:AW+2] == 0.
  - Out-of-range reads return 32'h0.
  - Out-of-range writes are dropped silently.
- Read path: rdata = mem[index], purely combinational, zero cycles of latency. rdata changes within the same cycle that addr changes.
- Write: at the rising edge of clk with rst=0, we=1 and addr in range, mem[index] <= wdata. Other words are unchanged.
- we=0: no array state changes, regardless of wdata.
- Read-during-write to the same word:
  - Before the edge, rdata shows the old contents.
  - After the edge, it shows wdata.
  - There is no write-through bypass.
- Reset:
  - At a rising edge with rst=1, all DEPTH words are cleared to 0 in that single edge.
  - rst has priority over we; a concurrent write is discarded.
  - While rst is held, rdata reflects the array contents, which read 0 after the first reset edge.
- Reset asserted mid-sequence discards all previously written data.
- No power-up initial value is guaranteed before the first reset edge. The core always applies reset first.
- No handshake: the memory is always ready.
- No X propagation: when addr is known, rdata is always a defined value after reset.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN = 32
  - DMEM_DEPTH = 256
  - function dmem_index(addr), which returns addr[AW+1:2]
  - function dmem_in_range(addr)
- Also place the word typedef word_t = logic [XLEN-1:0] in rv_pkg.
- No sub-module is needed; the array, write process and read mux live in data_mem.

Test Plan:
- Reset then read: rst=1 for one edge, rst=0, addr=0x00 -> rdata=0x00000000.
- Write then read back: write 0xA5A5A5A5 @0x04 and 0x12345678 @0x10 (we=1, one edge each). Read 0x04 -> 0xA5A5A5A5; read 0x10 -> 0x12345678; word @0x08 stays 0.
- Write-enable gating: addr=0x20, wdata=0xDEADBEEF, we=0 for one edge -> read 0x20 returns 0x00000000.
- Alignment aliasing and timing:
  - Write 0xCAFEF00D @0x13 -> read 0x10 returns 0xCAFEF00D.
  - Same-edge read of 0x10 before the write edge returns the old value 0x12345678.
- Out-of-range:
  - Write 0x11111111 @0x400 (DEPTH=256) -> read 0x400 returns 0, and word @0x00 is unchanged (no wrap).
- Reset priority mid-operation:
  - With 0xA5A5A5A5 stored @0x04, assert rst=1 and we=1 with wdata=0x55 @0x04 for one edge.
  - Result: reads of 0x04, 0x10 and 0x08 all return 0.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32 core constants, word type and data-memory address helpers
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int DMEM_DEPTH = 256;
    localparam int DMEM_AW    = $clog2(DMEM_DEPTH);

    typedef logic [XLEN-1:0] word_t;

    // Word index of a byte address; the two byte-offset bits are dropped.
    function automatic logic [DMEM_AW-1:0] dmem_index(input word_t addr);
        return DMEM_AW'(addr >> 2);
    endfunction

    function automatic logic dmem_in_range(input word_t addr);
        return (addr >> (DMEM_AW + 2)) == '0;
    endfunction

endpackage

// File: rtl/data_mem.sv
// rtl/data_mem.sv - word-addressed data memory: synchronous write, combinational read, clear-on-reset
module data_mem #(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int DEPTH = rv_pkg::DMEM_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]   word_idx;
    logic            in_range;

    // Byte offset is discarded so misaligned accesses alias to the containing word;
    // any set bit above the array span marks the access out of range (no wrap).
    assign word_idx = AW'(addr >> 2);
    assign in_range = (addr >> (AW + 2)) == '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && in_range) begin
            mem_q[word_idx] <= wdata;
        end
    end

    assign rdata = in_range ? mem_q[word_idx] : '0;

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - scoreboard bench for data_mem against a byte-address reference model
module tb_data_mem;

    localparam int NBYTES = 1024;   // 256 words of 4 bytes

    typedef struct {
        logic [31:0] exp;
        logic [31:0] addr;
        string       tag;
    } sb_item_t;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    int checks;
    int errors;

    sb_item_t sb_q[$];
    event     sample_ev;

    logic [31:0] model [int unsigned];

    data_mem dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned word_no;
        if (a >= NBYTES) return 32'h0;
        word_no = a / 4;
        if (model.exists(word_no)) return model[word_no];
        return 32'h0;
    endfunction

    // Apply one cycle of stimulus; the combinational read seen before the edge is queued as expected.
    task automatic cycle(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
        sb_item_t it;
        @(negedge clk);
        rst   = r;
        we    = w;
        addr  = a;
        wdata = d;
        it.exp  = model_read(a);
        it.addr = a;
        it.tag  = tag;
        sb_q.push_back(it);
        #1 -> sample_ev;
        @(posedge clk);
        if (r) model.delete();
        else if (w && a < NBYTES) model[a / 4] = d;
    endtask

    always begin
        sb_item_t it;
        @(sample_ev);
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow rdata=%08h expected=<queued item>", rdata);
        end else begin
            it = sb_q.pop_front();
            checks++;
            if (rdata !== it.exp) begin
                errors++;
                $display("FAIL %s addr=%08h rdata=%08h expected=%08h", it.tag, it.addr, rdata, it.exp);
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic        r;
        int unsigned sel;

        checks = 0;
        errors = 0;
        rst = 1'b0; we = 1'b0; addr = '0; wdata = '0;

        cycle(1, 0, 32'h0, 32'h0, "reset_edge");
        cycle(0, 0, 32'h00, 32'h0, "read_after_reset");

        cycle(0, 1, 32'h04, 32'hA5A5A5A5, "write_04");
        cycle(0, 1, 32'h10, 32'h12345678, "write_10");
        cycle(0, 0, 32'h04, 32'h0, "read_04");
        cycle(0, 0, 32'h10, 32'h0, "read_10");
        cycle(0, 0, 32'h08, 32'h0, "read_08_untouched");

        cycle(0, 0, 32'h20, 32'hDEADBEEF, "we0_edge");
        cycle(0, 0, 32'h20, 32'h0, "read_20_we0");

        cycle(0, 0, 32'h10, 32'h0, "pre_write_10_old");
        cycle(0, 1, 32'h13, 32'hCAFEF00D, "write_13_old_value");
        cycle(0, 0, 32'h10, 32'h0, "read_10_aliased");
        cycle(0, 0, 32'h11, 32'h0, "read_11_aliased");

        cycle(0, 1, 32'h400, 32'h11111111, "write_400_oor");
        cycle(0, 0, 32'h400, 32'h0, "read_400_oor");
        cycle(0, 0, 32'h00, 32'h0, "read_00_no_wrap");
        cycle(0, 0, 32'h3FC, 32'h0, "read_3fc_top");
        cycle(0, 1, 32'h3FC, 32'h0BADCAFE, "write_3fc_top");
        cycle(0, 0, 32'h3FC, 32'h0, "read_3fc_back");
        cycle(0, 0, 32'h80000010, 32'h0, "read_high_oor");

        cycle(1, 1, 32'h04, 32'h00000055, "reset_with_write");
        cycle(0, 0, 32'h04, 32'h0, "read_04_after_rst");
        cycle(0, 0, 32'h10, 32'h0, "read_10_after_rst");
        cycle(0, 0, 32'h08, 32'h0, "read_08_after_rst");
        cycle(0, 0, 32'h3FC, 32'h0, "read_3fc_after_rst");

        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 85)      a = $urandom_range(0, NBYTES - 1);
            else if (sel < 95) a = $urandom_range(NBYTES, 4 * NBYTES);
            else               a = $urandom();
            if (sel % 7 == 0)  a = a & 32'h0000_007F;   // concentrate some traffic for read-back hits
            d = $urandom();
            w = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 299) == 0);
            cycle(r, w, a, d, "random");
        end

        for (int i = 0; i < NBYTES; i += 4) begin
            cycle(0, 0, i, 32'h0, "final_sweep");
        end

        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
